// File: rtl/gray_stim_src_pkg.sv
// -----------------------------------------------------------------------------
// gray_stim_src_pkg
// Shared constants for the Gray-code stimulus source:
//   LCG_MUL / LCG_INC : C-library compatible linear-congruential coefficients
//   LCG_SEED_RST      : RNG state after reset
//   RAND_W            : width of the random output word
// Also provides lcg_next(), the single RNG state-advance step.
// -----------------------------------------------------------------------------
package gray_stim_src_pkg;

  localparam logic [31:0] LCG_MUL      = 32'd1103515245;
  localparam logic [31:0] LCG_INC      = 32'd12345;
  localparam logic [31:0] LCG_SEED_RST = 32'd1;
  localparam int          RAND_W       = 16;

  // One LCG step; the product is naturally truncated modulo 2^32.
  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    logic [31:0] prod_s;
    prod_s = s * LCG_MUL;
    return prod_s + LCG_INC;
  endfunction

endpackage

// File: rtl/gray_encode.sv
// -----------------------------------------------------------------------------
// gray_encode
// Combinational binary-to-Gray converter.
// Parameters: WIDTH - word width.
// Ports:
//   bin  - binary input word
//   gray - Gray-coded output, bin ^ (bin >> 1)
// -----------------------------------------------------------------------------
module gray_encode
  import gray_stim_src_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_stim_src.sv
// -----------------------------------------------------------------------------
// gray_stim_src
// Stimulus source for Gray-code datapaths: a free-running divider counter,
// an event counter with a Gray-coded view, and a 16-bit LCG random source
// that can be reseeded from the divider count.
//
// Build option: define GRAY_STIM_SRC_CHECK_EN to compile in a Gray round-trip
// checker driving a sticky err flag; otherwise err is tied to 0.
//
// Parameters: WIDTH (2..64) - divider / event counter width.
// Ports:
//   clk      - clock, rising edge
//   nrst     - asynchronous active-low reset
//   ena      - divider counter advance enable
//   cnt_ena  - event counter advance enable
//   reseed   - load RNG state from the current divider count
//   div_out  - divider count (bit i toggles at clk/2^(i+1) when ena=1)
//   bin_out  - event counter, binary
//   gray_out - Gray code of bin_out (combinational)
//   rand_out - random word, MSB always 0
//   err      - sticky Gray round-trip mismatch flag
// -----------------------------------------------------------------------------
module gray_stim_src
  import gray_stim_src_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ena,
  input  logic              cnt_ena,
  input  logic              reseed,
  output logic [WIDTH-1:0]  div_out,
  output logic [WIDTH-1:0]  bin_out,
  output logic [WIDTH-1:0]  gray_out,
  output logic [RAND_W-1:0] rand_out,
  output logic              err
);

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] bin_r;
  logic [31:0]      lcg_r;
  logic [31:0]      seed_s;

  // Seed is the divider count fitted to 32 bits (zero-extend or truncate).
  generate
    if (WIDTH < 32) begin : g_seed_ext
      assign seed_s = {{(32-WIDTH){1'b0}}, div_r};
    end else begin : g_seed_trunc
      assign seed_s = div_r[31:0];
    end
  endgenerate

  // Divider and event counters; both wrap modulo 2^WIDTH.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_r <= ZERO_W;
      bin_r <= ZERO_W;
    end else begin
      if (ena) begin
        div_r <= div_r + ONE_W;
      end else begin
        div_r <= div_r;
      end
      if (cnt_ena) begin
        bin_r <= bin_r + ONE_W;
      end else begin
        bin_r <= bin_r;
      end
    end
  end

  // RNG state: steps every cycle, reseed takes priority over stepping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lcg_r <= LCG_SEED_RST;
    end else if (reseed) begin
      lcg_r <= seed_s;
    end else begin
      lcg_r <= lcg_next(lcg_r);
    end
  end

  gray_encode #(
    .WIDTH (WIDTH)
  ) u_gray_encode (
    .bin  (bin_r),
    .gray (gray_out)
  );

  assign div_out  = div_r;
  assign bin_out  = bin_r;
  assign rand_out = {1'b0, lcg_r[30:16]};

`ifdef GRAY_STIM_SRC_CHECK_EN
  logic [WIDTH-1:0] dec_s;
  logic             err_r;

  // Inverse Gray: bit i is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    logic             acc;
    b   = ZERO_W;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  assign dec_s = gray_decode(gray_out);

  // Sticky round-trip mismatch flag, cleared only by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_r <= 1'b0;
    end else if (dec_s != bin_r) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_stim_src.sv
// -----------------------------------------------------------------------------
// tb_gray_stim_src
// Directed self-checking bench for gray_stim_src. A 32-bit instance covers
// reset, RNG sequence, Gray codes, enables, reseed and async reset; a 4-bit
// instance covers counter wrap-around.
// -----------------------------------------------------------------------------
module tb_gray_stim_src;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ena, cnt_ena, reseed;
  logic [31:0] div_out, bin_out, gray_out;
  logic [15:0] rand_out;
  logic        err;

  logic        ena4, cnt4, reseed4;
  logic [3:0]  div4, bin4, gray4;
  logic [15:0] rand4;
  logic        err4;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [31:0] gtab [8];
  logic [31:0] rtab [4];
  logic [3:0]  prev_gray4;

  always #5 clk = ~clk;

  gray_stim_src #(.WIDTH(32)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .ena      (ena),
    .cnt_ena  (cnt_ena),
    .reseed   (reseed),
    .div_out  (div_out),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .rand_out (rand_out),
    .err      (err)
  );

  gray_stim_src #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .nrst     (nrst),
    .ena      (ena4),
    .cnt_ena  (cnt4),
    .reseed   (reseed4),
    .div_out  (div4),
    .bin_out  (bin4),
    .gray_out (gray4),
    .rand_out (rand4),
    .err      (err4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    gtab = '{32'd0, 32'd1, 32'd3, 32'd2, 32'd6, 32'd7, 32'd5, 32'd4};
    rtab = '{32'd16838, 32'd5758, 32'd10113, 32'd17515};

    nrst    = 1'b0;
    ena     = 1'b1;
    cnt_ena = 1'b1;
    reseed  = 1'b0;
    ena4    = 1'b0;
    cnt4    = 1'b0;
    reseed4 = 1'b0;

    // Reset held with enables on: everything stays at reset value.
    tick(3);
    check("rst_div",   div_out,        32'd0);
    check("rst_bin",   bin_out,        32'd0);
    check("rst_gray",  gray_out,       32'd0);
    check("rst_rand",  32'(rand_out),  32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_bin4",  32'(bin4),      32'd0);
    check("rst_rand4", 32'(rand4),     32'd0);

    // Release reset: Gray table and RNG sequence on successive edges.
    nrst = 1'b1;
    #1;
    check("rel_gray0", gray_out, 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick(1);
      check("seq_bin",  bin_out,  32'(k));
      check("seq_div",  div_out,  32'(k));
      check("seq_gray", gray_out, gtab[k]);
      if (k <= 4) check("seq_rand", 32'(rand_out), rtab[k-1]);
    end

    // ena off: divider frozen, event counter advances by 10.
    ena = 1'b0;
    tick(10);
    check("en_div_hold", div_out, 32'd7);
    check("en_bin_adv",  bin_out, 32'd17);
    // Enables swapped.
    ena     = 1'b1;
    cnt_ena = 1'b0;
    tick(10);
    check("en_div_adv",  div_out,  32'd17);
    check("en_bin_hold", bin_out,  32'd17);
    check("en_gray17",   gray_out, 32'd25);

    // Bring divider to 100, then reseed from it.
    tick(83);
    check("pre_seed_div", div_out, 32'd100);
    ena    = 1'b0;
    reseed = 1'b1;
    tick(1);
    check("seed_rand", 32'(rand_out), 32'd0);
    // Reseed held for a second edge: seed wins over stepping.
    tick(1);
    check("seed_prio", 32'(rand_out), 32'd0);
    reseed = 1'b0;
    tick(1);
    // (100*1103515245+12345) mod 2^32 = 2977354445 -> bits [30:16] = 12662
    check("seed_step", 32'(rand_out), 32'd12662);

    // Wrap-around on the 4-bit instance: 14 -> 15 -> 0.
    cnt4 = 1'b1;
    tick(14);
    check("wrap_bin14",  32'(bin4),  32'd14);
    check("wrap_gray14", 32'(gray4), 32'h9);
    prev_gray4 = gray4;
    tick(1);
    check("wrap_gray15", 32'(gray4), 32'h8);
    check("wrap_1bit_a", 32'($countones(gray4 ^ prev_gray4)), 32'd1);
    prev_gray4 = gray4;
    tick(1);
    check("wrap_bin0",   32'(bin4),  32'd0);
    check("wrap_gray0",  32'(gray4), 32'h0);
    check("wrap_1bit_b", 32'($countones(gray4 ^ prev_gray4)), 32'd1);
    cnt4 = 1'b0;

    // Asynchronous reset mid-operation clears immediately.
    ena     = 1'b1;
    cnt_ena = 1'b1;
    tick(2);
    nrst = 1'b0;
    #1;
    check("async_div",  div_out,       32'd0);
    check("async_bin",  bin_out,       32'd0);
    check("async_rand", 32'(rand_out), 32'd0);
    tick(1);
    nrst = 1'b1;
    tick(1);
    check("resume_div",  div_out,       32'd1);
    check("resume_rand", 32'(rand_out), 32'd16838);

`ifdef GRAY_STIM_SRC_CHECK_EN
    tick(65536);
    check("chk_err_clean", 32'(err), 32'd0);
    cnt_ena = 1'b0;
    force dut.gray_out = (bin_out ^ (bin_out >> 1)) ^ 32'd1;
    tick(1);
    check("chk_err_set", 32'(err), 32'd1);
    release dut.gray_out;
    tick(3);
    check("chk_err_sticky", 32'(err), 32'd1);
    nrst = 1'b0;
    #1;
    check("chk_err_rst", 32'(err), 32'd0);
    nrst = 1'b1;
`else
    check("err_tied", 32'(err), 32'd0);
`endif
    check("err4_clean", 32'(err4), 32'd0);
    check("div4_hold",  32'(div4), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
